mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the synchronous 512x32 RAM port (read, write, address, data-in, data-out).
- Accepts single read/write requests from the control unit's MAR/MDR path over a valid/ready handshake.
- Sequences the RAM control strobes, captures read data in the single cycle it is valid, and returns a one-cycle response pulse.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DATA_W, 32, data word width.
- READ_LATENCY, 1, cycles from the RAM sampling a read until its output is valid; must be >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_W  read data; holds until the next read completes
- rsp_err  output  1  write-verify mismatch, qualified by rsp_valid
- mem_read  output  1  RAM read strobe
- mem_write  output  1  RAM write strobe
- mem_addr  output  ADDR_W  RAM address, registered
- mem_wdata  output  DATA_W  RAM write data, registered
- mem_rdata  input  DATA_W  RAM data out; X whenever read was not sampled

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE; mem_read=mem_write=0; mem_addr=0; mem_wdata=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; latency counter=0.
- req_ready=1 only in IDLE. Accept on a rising edge with req_valid && req_ready.
  - Accept registers addr, wdata and write into mem_addr, mem_wdata and op.
  - While busy, req_valid is ignored; the requester holds the request until accepted.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE (plus VFY_READ and VFY_WAIT with the optional feature).
- Read, with E0 = accept edge:
  - RD_ISSUE (E0-E1): mem_read=1.
  - RD_WAIT: lasts READ_LATENCY cycles with mem_read held at 1 so RAM output stays defined.
  - At the end of the last RD_WAIT cycle: rsp_rdata<=mem_rdata, rsp_valid<=1, state->IDLE.
  - With READ_LATENCY=1, rsp_valid is high E2-E3.
- Write:
  - WR_ISSUE (E0-E1): mem_write=1, mem_read=0.
  - At E1: rsp_valid<=1, rsp_err<=0, state->IDLE. The write ack is high E1-E2.
- mem_read and mem_write are never both 1. Both are 0 in IDLE.
- mem_addr and mem_wdata hold their last values in IDLE; they change only on accept.
- rsp_valid is exactly one cycle per accepted request. A new request may be accepted in the same cycle rsp_valid is high, giving back-to-back throughput with no dead cycle.
- Latency counter: width is clog2(READ_LATENCY+1). It loads READ_LATENCY-1 on entry to RD_WAIT and decrements; exit at 0. No wrap.
- Reset mid-operation: strobes drop immediately, the operation is abandoned, no rsp_valid, and rsp_rdata clears to 0. A RAM write whose strobe was already sampled stands.
- rsp_rdata never captures X from an idle RAM: capture happens only on the final wait cycle.

Optional Feature:
- MEM_WRITE_VERIFY_EN defined:
  - Sequence: WR_ISSUE -> VFY_READ (mem_read=1) -> VFY_WAIT (READ_LATENCY cycles, mem_read=1).
  - On exit from VFY_WAIT: compare mem_rdata to the registered wdata; rsp_err<=mismatch; rsp_valid<=1; rsp_rdata unchanged.
  - Write ack moves from E1 to E(2+READ_LATENCY).
- Undefined: verify states are absent and rsp_err is tied 0.

Decomposition:
- Package mem_ctrl_pkg holds:
  - ADDR_W/DATA_W defaults (9/32).
  - The state enum (IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, VFY_READ, VFY_WAIT).
  - An op encoding constant (OP_RD=0, OP_WR=1).
- No sub-module is natural: the FSM and latency counter stay in one module.

Test Plan:
- Reset: reset_n=0 for 3 cycles mid-idle -> all outputs 0, req_ready=1 after release.
- Write then read: write addr 9'h00A data 32'hDEADBEEF; rsp_valid one cycle after accept; then read 9'h00A -> rsp_valid 2 cycles after accept, rsp_rdata=32'hDEADBEEF, mem_read high exactly 2 cycles.
- Back-to-back: hold req_valid across read 9'h000 then write 9'h1FF=32'h1 -> second request accepted on the rsp_valid cycle of the first; mem_read and mem_write never overlap.
- Busy stall: assert a second request during RD_WAIT -> req_ready=0, mem_addr unchanged, request taken on return to IDLE.
- Reset mid-read: drop reset_n during RD_WAIT -> mem_read=0 asynchronously, no rsp_valid, state IDLE after release.
- With MEM_WRITE_VERIFY_EN:
  - Write 9'h055=32'hA5A5A5A5 -> rsp_valid at accept+3, rsp_err=0.
  - Force the RAM model to return 32'h0 -> rsp_err=1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    // Operation latched at accept time
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        VFY_READ = 3'd4,
        VFY_WAIT = 3'd5
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator side of a synchronous single-port RAM: takes one read or write
// request at a time over valid/ready, drives the RAM strobes, captures read
// data on the last wait cycle and returns a one-cycle completion pulse.
//
// Optional feature macro: MEM_WRITE_VERIFY_EN
//   When defined, every write is followed by a read-back of the same address
//   and rsp_err reports a mismatch. When undefined, rsp_err is tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a request, strobes low, addr/wdata holding
// RD_ISSUE | first read cycle, mem_read high
// RD_WAIT  | READ_LATENCY cycles, mem_read held, capture on last cycle
// WR_ISSUE | single write cycle, mem_write high
// VFY_READ | read-back of the written word, mem_read high (verify only)
// VFY_WAIT | READ_LATENCY cycles, compare on last cycle (verify only)
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic wait_done;
    logic op_done;
    logic rd_strobe;
    logic wr_strobe;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign wait_done = (cnt_q == '0);

    // State and latency counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and latency counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_write ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = CNT_LOAD;
            end
            RD_WAIT: begin
                if (wait_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef MEM_WRITE_VERIFY_EN
            WR_ISSUE: begin
                state_d = VFY_READ;
            end
            VFY_READ: begin
                state_d = VFY_WAIT;
                cnt_d   = CNT_LOAD;
            end
            VFY_WAIT: begin
                if (wait_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`else
            WR_ISSUE: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe decode and completion detect from the current state
    always_comb begin
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
        op_done   = 1'b0;
        case (state_q)
            RD_ISSUE: begin
                rd_strobe = 1'b1;
            end
            RD_WAIT: begin
                rd_strobe = 1'b1;
                op_done   = wait_done;
            end
            WR_ISSUE: begin
                wr_strobe = 1'b1;
`ifndef MEM_WRITE_VERIFY_EN
                op_done   = 1'b1;
`endif
            end
`ifdef MEM_WRITE_VERIFY_EN
            VFY_READ: begin
                rd_strobe = 1'b1;
            end
            VFY_WAIT: begin
                rd_strobe = 1'b1;
                op_done   = wait_done;
            end
`endif
            default: begin
                rd_strobe = 1'b0;
            end
        endcase
    end

    assign mem_read  = rd_strobe;
    assign mem_write = wr_strobe;

    // Request capture and response generation
    always_comb begin
        op_d        = op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            op_d        = req_write ? OP_WR : OP_RD;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
        end
        rsp_valid_d = op_done;
        // Only a finishing read updates rsp_rdata, so idle RAM output is never seen
        rsp_rdata_d = (op_done && (op_q == OP_RD)) ? mem_rdata : rsp_rdata_q;
    end

    // Request and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= OP_RD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            op_q        <= op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_WRITE_VERIFY_EN
    logic rsp_err_q, rsp_err_d;

    // Write read-back compare; reads always report no error
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (op_done) begin
            rsp_err_d = (op_q == OP_WR) && (mem_rdata != mem_wdata_q);
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural RAM and a
// word-array reference model. Build with MEM_WRITE_VERIFY_EN to exercise
// the write read-back path.
module tb_mem_access_ctrl;

    localparam int RL = 1;
    localparam int RD_LAT = 1 + RL;
`ifdef MEM_WRITE_VERIFY_EN
    localparam int WR_LAT = 2 + RL;
    localparam bit VFY = 1'b1;
`else
    localparam int WR_LAT = 1;
    localparam bit VFY = 1'b0;
`endif
    localparam logic [31:0] POISON = 32'hBAD0_0BAD;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(RL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram   [512];
    logic [31:0] model [512];
    logic [31:0] rd_pipe [RL];
    logic [31:0] last_rd;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic        corrupt;
    logic        overlap;
    int          cyc;
    int          rd_run;
    int          wr_run;
    int          vectors;
    int          errs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Synchronous RAM: samples a read on the edge, data valid RL cycles later
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_read ? (corrupt ? 32'h0 : ram[mem_addr]) : POISON;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Accept observer: reference model updates and expected responses
    always @(posedge clk) begin
        if (reset_n && req_valid && req_ready) begin
            exp_t e;
            e.err = 1'b0;
            if (req_write) begin
                model[req_addr] = req_wdata;
                e.err = VFY && corrupt;
                e.cyc = cyc + 1 + WR_LAT;
            end else begin
                last_rd = model[req_addr];
                e.cyc = cyc + 1 + RD_LAT;
            end
            e.rdata   = last_rd;
            exp_addr  = req_addr;
            exp_wdata = req_wdata;
            sb.push_back(e);
        end
    end

    // Response monitor and strobe-shape checks
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_run = 0;
            wr_run = 0;
        end else begin
            if (mem_read && mem_write) overlap = 1'b1;
            if (mem_read) rd_run++;
            else if (rd_run != 0) begin
                chk("mem_read_len", 32'(rd_run), 32'(RD_LAT));
                rd_run = 0;
            end
            if (mem_write) wr_run++;
            else if (wr_run != 0) begin
                chk("mem_write_len", 32'(wr_run), 32'd1);
                wr_run = 0;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                    chk("mem_wdata", mem_wdata, exp_wdata);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d,
                         output logic rsp_at_acc);
        int n = 0;
        rsp_at_acc = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        rsp_at_acc = rsp_valid;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    endtask

    task automatic clear_model_after_reset();
        sb.delete();
        last_rd   = 32'h0;
        exp_addr  = 9'h0;
        exp_wdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errs %0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        logic rv;
        logic [8:0]  a;
        logic [31:0] d;
        logic        w;
        vectors = 0;
        errs    = 0;
        cyc     = 0;
        rd_run  = 0;
        wr_run  = 0;
        overlap = 1'b0;
        corrupt = 1'b0;
        rd_pipe[0] = POISON;
        for (int i = 0; i < 512; i++) begin
            d = $urandom;
            ram[i]   = d;
            model[i] = d;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 9'h0;
        req_wdata = 32'h0;
        clear_model_after_reset();

        // Power-on reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Write then read back the same word
        issue(1'b1, 9'h00A, 32'hDEADBEEF, rv);
        issue(1'b0, 9'h00A, 32'h0, rv);
        drain();
        chk("wr_rd_data", rsp_rdata, 32'hDEADBEEF);

        // Reset while idle
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        clear_model_after_reset();
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_rst_ready", 32'(req_ready), 32'd1);

        // Back-to-back: second request accepted while first response is high
        issue(1'b0, 9'h000, 32'h0, rv);
        issue(1'b1, 9'h1FF, 32'h1, rv);
        chk("b2b_accept_on_rsp", 32'(rv), 32'd1);
        drain();

        // Busy stall: request held during a read is not taken until idle
        issue(1'b0, 9'h00A, 32'h0, rv);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h003;
        req_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_ready", 32'(req_ready), 32'd0);
        chk("stall_mem_addr", 32'(mem_addr), 32'h00A);
        issue(1'b0, 9'h003, 32'h0, rv);
        drain();

        // Reset during the wait phase of a read
        issue(1'b0, 9'h1FF, 32'h0, rv);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        clear_model_after_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);

`ifdef MEM_WRITE_VERIFY_EN
        // Write with read-back: clean, then with the RAM returning zero
        issue(1'b1, 9'h055, 32'hA5A5A5A5, rv);
        drain();
        chk("vfy_clean_err", 32'(rsp_err), 32'd0);
        corrupt = 1'b1;
        issue(1'b1, 9'h056, 32'hA5A5A5A5, rv);
        drain();
        corrupt = 1'b0;
        chk("vfy_bad_err", 32'(rsp_err), 32'd1);
`endif

        // Randomised traffic over a small address window plus the top word
        for (int k = 0; k < 60; k++) begin
            a = 9'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = 9'h1FF;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            issue(w, a, d, rv);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("strobe_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
